micro_mac_in_cond: RTL and testbench

- Input conditioning stage directly upstream of micro_mac; drives its i_x1, i_x2 and i_x3 inputs.
- Each of the three raw, asynchronous, possibly bouncing control lines goes through a 2-flop synchroniser, then a counter-based debouncer.
- Publishes clean levels plus single-cycle rise/fall strobes, so micro_mac only ever sees stable, synchronous inputs.

---
 rtl/micro_mac_pkg.sv | 13 +
 rtl/micro_mac_db_ch.sv | 94 +++++++++
 rtl/micro_mac_in_cond.sv | 37 +++
 tb/tb_micro_mac_in_cond.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/micro_mac_pkg.sv
// micro_mac input conditioning: shared constants and
// the per-channel debounce state encoding.
package micro_mac_pkg;

  localparam int N_CH      = 3;
  localparam int DB_CYCLES = 4;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_e;

endpackage

// File: rtl/micro_mac_db_ch.sv
// One conditioned input: 2-flop synchroniser, tick-qualified
// debounce counter and registered rise/fall strobes.
module micro_mac_db_ch #(
  parameter int DB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_x,
  output logic o_rise,
  output logic o_fall
);
  import micro_mac_pkg::*;

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES);

  logic             sync1;
  logic             sync2;
  db_state_e        state;
  db_state_e        state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  logic             diff;
  logic             hit;
  logic             x_n;
  logic             rise_n;
  logic             fall_n;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      state  <= STABLE;
      cnt    <= '0;
      o_x    <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      sync1  <= i_raw;
      sync2  <= sync1;
      state  <= state_n;
      cnt    <= cnt_n;
      o_x    <= x_n;
      o_rise <= rise_n;
      o_fall <= fall_n;
    end
  end

  // cnt is 0 in STABLE, so one increment covers both states
  assign cnt_inc = cnt + 1'b1;
  assign diff    = (sync2 != o_x);
  assign hit     = diff && i_tick && (cnt_inc == LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = o_x;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    if (hit) begin
      x_n     = sync2;
      rise_n  = sync2;
      fall_n  = ~sync2;
      state_n = STABLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        STABLE: begin
          cnt_n = '0;
          if (diff) begin
            state_n = PENDING;
            if (i_tick) cnt_n = cnt_inc;
          end
        end
        PENDING: begin
          if (!diff) begin
            state_n = STABLE;
            cnt_n   = '0;
          end else if (i_tick) begin
            cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n = STABLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/micro_mac_in_cond.sv
// Conditions the raw micro_mac control lines into clean,
// synchronous levels plus edge strobes and a change flag.
module micro_mac_in_cond #(
  parameter int N_CH      = micro_mac_pkg::N_CH,
  parameter int DB_CYCLES = micro_mac_pkg::DB_CYCLES
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_tick,
  input  logic [N_CH-1:0] i_x_raw,
  output logic [N_CH-1:0] o_x,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic            o_change
);
  import micro_mac_pkg::*;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    micro_mac_db_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_tick(i_tick),
      .i_raw (i_x_raw[g]),
      .o_x   (o_x[g]),
      .o_rise(o_rise[g]),
      .o_fall(o_fall[g])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_change <= 1'b0;
    else       o_change <= |{o_rise, o_fall};
  end

endmodule

// File: tb/tb_micro_mac_in_cond.sv
// Bench for micro_mac_in_cond: cycle model of the debounce
// rules plus directed literal checks.
module tb_micro_mac_in_cond;
  localparam int NC = 3;
  localparam int DB = 4;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          tick = 1'b1;
  logic [NC-1:0] raw  = '1;
  logic [NC-1:0] o_x;
  logic [NC-1:0] o_rise;
  logic [NC-1:0] o_fall;
  logic          o_change;

  int checks = 0;
  int errors = 0;

  micro_mac_in_cond #(
    .N_CH(NC),
    .DB_CYCLES(DB)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_tick  (tick),
    .i_x_raw (raw),
    .o_x     (o_x),
    .o_rise  (o_rise),
    .o_fall  (o_fall),
    .o_change(o_change)
  );

  always #5 clk = ~clk;

  // model: s is raw delayed two edges; a level is taken
  // once s has differed on DB ticked cycles without a gap
  logic [NC-1:0] m_s1, m_s2, m_x, m_r, m_f;
  logic          m_c;
  int            m_run [NC];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0;
      m_s2 = '0;
      m_x  = '0;
      m_r  = '0;
      m_f  = '0;
      m_c  = 1'b0;
      for (int c = 0; c < NC; c++) m_run[c] = 0;
    end else begin
      m_c = |{m_r, m_f};
      m_r = '0;
      m_f = '0;
      for (int c = 0; c < NC; c++) begin
        if (m_s2[c] != m_x[c]) begin
          if (tick) m_run[c] = m_run[c] + 1;
          if (m_run[c] == DB) begin
            m_x[c]   = m_s2[c];
            m_r[c]   = m_s2[c];
            m_f[c]   = ~m_s2[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  end

  logic          lit_req = 1'b0;
  string         lit_name = "";
  logic [NC-1:0] lit_x, lit_r, lit_f;
  logic          lit_c;

  always @(negedge clk) begin
    checks++;
    if ({o_x, o_rise, o_fall, o_change} !==
        {m_x, m_r, m_f, m_c}) begin
      errors++;
      $display("FAIL model t=%0t got x=%b r=%b f=%b c=%b want x=%b r=%b f=%b c=%b",
               $time, o_x, o_rise, o_fall, o_change,
               m_x, m_r, m_f, m_c);
    end
    if (lit_req) begin
      checks++;
      if ({o_x, o_rise, o_fall, o_change} !==
          {lit_x, lit_r, lit_f, lit_c}) begin
        errors++;
        $display("FAIL %s t=%0t got x=%b r=%b f=%b c=%b want x=%b r=%b f=%b c=%b",
                 lit_name, $time, o_x, o_rise, o_fall, o_change,
                 lit_x, lit_r, lit_f, lit_c);
      end
    end
  end

  int cyc = 0;
  bit tick_div = 1'b0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      tick = !tick_div || (cyc % 4 == 0);
    end
  endtask

  task automatic chk(input string nm,
                     input logic [NC-1:0] x,
                     input logic [NC-1:0] r,
                     input logic [NC-1:0] f,
                     input logic c);
    lit_name = nm;
    lit_x = x;
    lit_r = r;
    lit_f = f;
    lit_c = c;
    lit_req = 1'b1;
    @(negedge clk);
    #1;
    lit_req = 1'b0;
  endtask

  int seq [10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

  initial begin
    // 1: raw high through reset
    step(3);
    chk("rst_hold", 3'b000, 3'b000, 3'b000, 1'b0);
    step(1);
    rst = 1'b0;
    step(5);
    chk("t1_e5", 3'b000, 3'b000, 3'b000, 1'b0);
    step(1);
    chk("t1_e6", 3'b111, 3'b111, 3'b000, 1'b0);
    step(1);
    chk("t1_e7", 3'b111, 3'b000, 3'b000, 1'b1);
    step(1);
    chk("t1_e8", 3'b111, 3'b000, 3'b000, 1'b0);
    raw = 3'b000;
    step(6);
    chk("t1_fall", 3'b000, 3'b000, 3'b111, 1'b0);
    step(1);
    chk("t1_fchg", 3'b000, 3'b000, 3'b000, 1'b1);
    step(3);

    // 2: clean rise then fall on ch0
    raw = 3'b001;
    step(5);
    chk("t2_e5", 3'b000, 3'b000, 3'b000, 1'b0);
    step(1);
    chk("t2_rise", 3'b001, 3'b001, 3'b000, 1'b0);
    step(1);
    chk("t2_chg", 3'b001, 3'b000, 3'b000, 1'b1);
    step(18);
    raw = 3'b000;
    step(5);
    chk("t2_f_e5", 3'b001, 3'b000, 3'b000, 1'b0);
    step(1);
    chk("t2_fall", 3'b000, 3'b000, 3'b001, 1'b0);
    step(1);
    chk("t2_fchg", 3'b000, 3'b000, 3'b000, 1'b1);
    step(3);

    // 3: pulse-width boundary on ch1
    raw = 3'b010;
    step(3);
    raw = 3'b000;
    step(10);
    chk("t3_short", 3'b000, 3'b000, 3'b000, 1'b0);
    raw = 3'b010;
    step(4);
    raw = 3'b000;
    step(2);
    chk("t3_rise", 3'b010, 3'b010, 3'b000, 1'b0);
    step(3);
    chk("t3_hold", 3'b010, 3'b000, 3'b000, 1'b0);
    step(1);
    chk("t3_fall", 3'b000, 3'b000, 3'b010, 1'b0);
    step(5);

    // 4: bouncing ch2
    for (int i = 0; i < 10; i++) begin
      raw = {seq[i][0], 2'b00};
      step(1);
    end
    chk("t4_wait", 3'b000, 3'b000, 3'b000, 1'b0);
    step(1);
    chk("t4_rise", 3'b100, 3'b100, 3'b000, 1'b0);
    step(1);
    chk("t4_chg", 3'b100, 3'b000, 3'b000, 1'b1);
    raw = 3'b000;
    step(10);
    chk("t4_back", 3'b000, 3'b000, 3'b000, 1'b0);

    // 5: tick every 4th clock
    tick_div = 1'b1;
    raw = 3'b001;
    step(40);
    chk("t5_rise", 3'b001, 3'b000, 3'b000, 1'b0);
    raw = 3'b000;
    step(40);
    chk("t5_fall", 3'b000, 3'b000, 3'b000, 1'b0);
    raw = 3'b001;
    step(6);
    raw = 3'b000;
    step(1);
    raw = 3'b001;
    step(40);
    chk("t5_drop", 3'b001, 3'b000, 3'b000, 1'b0);
    tick_div = 1'b0;
    raw = 3'b000;
    step(12);
    chk("t5_end", 3'b000, 3'b000, 3'b000, 1'b0);

    // 6: async reset while ch0 is pending
    raw = 3'b101;
    step(10);
    chk("t6_set", 3'b101, 3'b000, 3'b000, 1'b0);
    raw = 3'b100;
    step(4);
    #2;
    rst = 1'b1;
    raw = 3'b000;
    chk("t6_rst", 3'b000, 3'b000, 3'b000, 1'b0);
    step(1);
    rst = 1'b0;
    step(20);
    chk("t6_quiet", 3'b000, 3'b000, 3'b000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
